// File: rtl/cpu_pkg.sv
// Shared CPU memory-side types: response owner encoding and arbiter defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int WORD_W           = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-input priority picker: hi wins unless lo has watched LIMIT consecutive hi grants.
// Grant is combinational in the request cycle; requesters hold req until granted.
module mem_arb_pick
  import cpu_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_hi_req,
  input  logic i_lo_req,
  output logic o_hi_gnt,
  output logic o_lo_gnt
);

  localparam int            CW      = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          force_lo;

  always_comb begin
    force_lo = (cnt_q == CNT_MAX);
    o_lo_gnt = 1'b0;
    o_hi_gnt = 1'b0;
    if (!i_reset) begin
      o_lo_gnt = i_lo_req && (!i_hi_req || force_lo);
      o_hi_gnt = i_hi_req && !o_lo_gnt;
    end
  end

  // Counts hi grants only while lo is actually waiting; saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (i_reset || !i_lo_req || o_lo_gnt) begin
      cnt_d = '0;
    end else if (o_hi_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-cycle memory; grant in cycle N, response in N+1.
// Data has priority; fetch is forced after STARVE_LIMIT consecutive data grants while it waits.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = 30
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [31:0]       o_if_data,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [31:0]       i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_valid,
  output logic [31:0]       o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [AW-1:0]     o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  logic   if_gnt, d_gnt;
  owner_e own_q, own_d;
  logic   store_q, store_d;
  logic   if_resp, d_resp;
  logic [WORD_W-1:0] if_data_q, if_data_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic [WORD_W-1:0] d_resp_dat;
  logic   unused_addr_lsb;

  assign unused_addr_lsb = ^{i_if_addr[1:0], i_d_addr[1:0]};

  mem_arb_pick #(
    .LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_hi_req (i_d_req),
    .i_lo_req (i_if_req),
    .o_hi_gnt (d_gnt),
    .o_lo_gnt (if_gnt)
  );

  // Owner of the next-cycle response; a store remembers it must return zero data.
  always_comb begin
    own_d   = OWN_NONE;
    store_d = 1'b0;
    if (!i_reset) begin
      if (d_gnt) begin
        own_d   = OWN_D;
        store_d = i_d_we;
      end else if (if_gnt) begin
        own_d   = OWN_IF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      own_q   <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      own_q   <= own_d;
      store_q <= store_d;
    end
  end

  // Response side: memory data is only valid in the cycle after the grant, so it is
  // forwarded directly and captured so the outputs hold between pulses.
  always_comb begin
    if_resp    = !i_reset && (own_q == OWN_IF);
    d_resp     = !i_reset && (own_q == OWN_D);
    d_resp_dat = store_q ? '0 : i_mem_rdata;
    if_data_d  = if_resp ? i_mem_rdata : if_data_q;
    d_rdata_d  = d_resp ? d_resp_dat : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    o_if_gnt    = if_gnt;
    o_d_gnt     = d_gnt;
    o_if_valid  = if_resp;
    o_d_valid   = d_resp;
    o_if_data   = i_reset ? '0 : if_data_d;
    o_d_rdata   = i_reset ? '0 : d_rdata_d;
    o_mem_en    = if_gnt || d_gnt;
    o_mem_we    = d_gnt && i_d_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (d_gnt) begin
      o_mem_addr = i_d_addr[AW+1:2];
      if (i_d_we) begin
        o_mem_wdata = i_d_wdata;
      end
    end else if (if_gnt) begin
      o_mem_addr = i_if_addr[AW+1:2];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven on negedge, outputs sampled 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [31:0] o_if_data;
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_gnt;
  logic        o_d_valid;
  logic [31:0] o_d_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [29:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .AW(30)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_valid  (o_if_valid),
    .o_if_data   (o_if_data),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_gnt     (o_d_gnt),
    .o_d_valid   (o_d_valid),
    .o_d_rdata   (o_d_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  task automatic idle_inputs();
    i_if_req    = 1'b0;
    i_if_addr   = '0;
    i_d_req     = 1'b0;
    i_d_we      = 1'b0;
    i_d_addr    = '0;
    i_d_wdata   = '0;
    i_mem_rdata = '0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    next_cyc();
    i_reset = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h40; i_d_req = 1'b1; i_d_we = 1'b1;
    i_d_addr = 32'h80; i_d_wdata = 32'h1234_5678; i_mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (o_if_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_if_gnt got %b want 0", o_if_gnt); end
    n_cmp++; if (o_d_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_d_gnt got %b want 0", o_d_gnt); end
    n_cmp++; if (o_mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %b want 0", o_mem_en); end
    n_cmp++; if (o_mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %b want 0", o_mem_we); end
    n_cmp++; if (o_if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid got %b want 0", o_if_valid); end
    n_cmp++; if (o_d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid got %b want 0", o_d_valid); end
    n_cmp++; if (o_if_data !== 32'h0) begin n_bad++; $display("FAIL rst_if_data got %h want 0", o_if_data); end
    n_cmp++; if (o_d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_d_rdata got %h want 0", o_d_rdata); end
    next_cyc();
    idle_inputs(); i_reset = 1'b0;
    #1;
    n_cmp++; if (o_mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_mem_en got %b want 0", o_mem_en); end
    n_cmp++; if ({o_if_gnt, o_d_gnt, o_mem_we} !== 3'b000) begin n_bad++; $display("FAIL idle_gnts got %b want 000", {o_if_gnt, o_d_gnt, o_mem_we}); end
  endtask

  task automatic test_fetch();
    next_cyc();
    i_if_req = 1'b1; i_if_addr = 32'h10;
    #1;
    n_cmp++; if ({o_if_gnt, o_d_gnt, o_mem_en, o_mem_we} !== 4'b1010) begin n_bad++; $display("FAIL f0_ctl got %b want 1010", {o_if_gnt, o_d_gnt, o_mem_en, o_mem_we}); end
    n_cmp++; if (o_mem_addr !== 30'h4) begin n_bad++; $display("FAIL f0_addr got %h want 4", o_mem_addr); end
    n_cmp++; if (o_if_valid !== 1'b0) begin n_bad++; $display("FAIL f0_valid got %b want 0", o_if_valid); end
    next_cyc();
    i_if_addr = 32'h14; i_mem_rdata = 32'hE3A0_1005;
    #1;
    n_cmp++; if (o_if_gnt !== 1'b1) begin n_bad++; $display("FAIL f1_gnt got %b want 1", o_if_gnt); end
    n_cmp++; if (o_mem_addr !== 30'h5) begin n_bad++; $display("FAIL f1_addr got %h want 5", o_mem_addr); end
    n_cmp++; if (o_if_valid !== 1'b1) begin n_bad++; $display("FAIL f1_valid got %b want 1", o_if_valid); end
    n_cmp++; if (o_if_data !== 32'hE3A0_1005) begin n_bad++; $display("FAIL f1_data got %h want e3a01005", o_if_data); end
    next_cyc();
    i_if_req = 1'b0; i_mem_rdata = 32'hE581_2000;
    #1;
    n_cmp++; if (o_if_valid !== 1'b1) begin n_bad++; $display("FAIL f2_valid got %b want 1", o_if_valid); end
    n_cmp++; if (o_if_data !== 32'hE581_2000) begin n_bad++; $display("FAIL f2_data got %h want e5812000", o_if_data); end
    n_cmp++; if (o_mem_en !== 1'b0) begin n_bad++; $display("FAIL f2_mem_en got %b want 0", o_mem_en); end
    next_cyc();
    i_mem_rdata = 32'h0BAD_0BAD;
    #1;
    n_cmp++; if (o_if_valid !== 1'b0) begin n_bad++; $display("FAIL f3_valid got %b want 0", o_if_valid); end
    n_cmp++; if (o_if_data !== 32'hE581_2000) begin n_bad++; $display("FAIL f3_hold got %h want e5812000", o_if_data); end
    idle_inputs();
  endtask

  task automatic test_priority();
    next_cyc();
    i_if_req = 1'b1; i_if_addr = 32'h20; i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h100;
    #1;
    n_cmp++; if ({o_d_gnt, o_if_gnt} !== 2'b10) begin n_bad++; $display("FAIL p0_gnts got %b want 10", {o_d_gnt, o_if_gnt}); end
    n_cmp++; if (o_mem_addr !== 30'h40) begin n_bad++; $display("FAIL p0_addr got %h want 40", o_mem_addr); end
    next_cyc();
    i_d_req = 1'b0; i_mem_rdata = 32'h1111_1111;
    #1;
    n_cmp++; if ({o_d_gnt, o_if_gnt} !== 2'b01) begin n_bad++; $display("FAIL p1_gnts got %b want 01", {o_d_gnt, o_if_gnt}); end
    n_cmp++; if (o_mem_addr !== 30'h8) begin n_bad++; $display("FAIL p1_addr got %h want 8", o_mem_addr); end
    n_cmp++; if ({o_d_valid, o_if_valid} !== 2'b10) begin n_bad++; $display("FAIL p1_valids got %b want 10", {o_d_valid, o_if_valid}); end
    n_cmp++; if (o_d_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL p1_d_rdata got %h want 11111111", o_d_rdata); end
    next_cyc();
    i_if_req = 1'b0; i_mem_rdata = 32'h2222_2222;
    #1;
    n_cmp++; if ({o_d_valid, o_if_valid} !== 2'b01) begin n_bad++; $display("FAIL p2_valids got %b want 01", {o_d_valid, o_if_valid}); end
    n_cmp++; if (o_if_data !== 32'h2222_2222) begin n_bad++; $display("FAIL p2_if_data got %h want 22222222", o_if_data); end
    n_cmp++; if (o_d_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL p2_d_hold got %h want 11111111", o_d_rdata); end
    idle_inputs();
  endtask

  task automatic test_store();
    next_cyc();
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h104; i_d_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({o_d_gnt, o_mem_en, o_mem_we} !== 3'b111) begin n_bad++; $display("FAIL s0_ctl got %b want 111", {o_d_gnt, o_mem_en, o_mem_we}); end
    n_cmp++; if (o_mem_addr !== 30'h41) begin n_bad++; $display("FAIL s0_addr got %h want 41", o_mem_addr); end
    n_cmp++; if (o_mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL s0_wdata got %h want deadbeef", o_mem_wdata); end
    next_cyc();
    i_d_req = 1'b0; i_d_we = 1'b0; i_mem_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (o_d_valid !== 1'b1) begin n_bad++; $display("FAIL s1_valid got %b want 1", o_d_valid); end
    n_cmp++; if (o_d_rdata !== 32'h0) begin n_bad++; $display("FAIL s1_rdata got %h want 0", o_d_rdata); end
    n_cmp++; if (o_if_valid !== 1'b0) begin n_bad++; $display("FAIL s1_if_valid got %b want 0", o_if_valid); end
    next_cyc();
    i_d_req = 1'b1; i_d_addr = 32'h103;
    #1;
    n_cmp++; if (o_mem_addr !== 30'h40) begin n_bad++; $display("FAIL align_addr got %h want 40", o_mem_addr); end
    n_cmp++; if (o_d_valid !== 1'b0) begin n_bad++; $display("FAIL s2_valid got %b want 0", o_d_valid); end
    next_cyc();
    idle_inputs();
  endtask

  task automatic test_starve();
    logic exp_if;
    logic exp_ifv;
    next_cyc();
    i_if_req = 1'b1; i_if_addr = 32'h40; i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      i_mem_rdata = 32'hA000_0000 + i;
      #1;
      exp_if  = ((i % 5) == 4);
      exp_ifv = ((i % 5) == 0) && (i > 0);
      n_cmp++; if ({o_if_gnt, o_d_gnt} !== {exp_if, !exp_if}) begin n_bad++; $display("FAIL starve_gnt[%0d] got %b want %b", i, {o_if_gnt, o_d_gnt}, {exp_if, !exp_if}); end
      n_cmp++; if (o_mem_addr !== (exp_if ? 30'h10 : 30'hC0)) begin n_bad++; $display("FAIL starve_addr[%0d] got %h want %h", i, o_mem_addr, (exp_if ? 30'h10 : 30'hC0)); end
      n_cmp++; if (o_if_valid !== exp_ifv) begin n_bad++; $display("FAIL starve_ifv[%0d] got %b want %b", i, o_if_valid, exp_ifv); end
      next_cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    next_cyc();
    i_if_req = 1'b1; i_if_addr = 32'h30;
    #1;
    n_cmp++; if (o_if_gnt !== 1'b1) begin n_bad++; $display("FAIL ri0_gnt got %b want 1", o_if_gnt); end
    next_cyc();
    i_reset = 1'b1; i_mem_rdata = 32'h5555_5555;
    #1;
    n_cmp++; if (o_if_valid !== 1'b0) begin n_bad++; $display("FAIL ri1_valid got %b want 0", o_if_valid); end
    n_cmp++; if (o_if_data !== 32'h0) begin n_bad++; $display("FAIL ri1_data got %h want 0", o_if_data); end
    n_cmp++; if ({o_if_gnt, o_mem_en} !== 2'b00) begin n_bad++; $display("FAIL ri1_gnt got %b want 00", {o_if_gnt, o_mem_en}); end
    next_cyc();
    i_reset = 1'b0; i_if_addr = 32'h34; i_mem_rdata = 32'h6666_6666;
    #1;
    n_cmp++; if ({o_if_gnt, o_mem_en} !== 2'b11) begin n_bad++; $display("FAIL ri2_gnt got %b want 11", {o_if_gnt, o_mem_en}); end
    n_cmp++; if (o_mem_addr !== 30'hD) begin n_bad++; $display("FAIL ri2_addr got %h want d", o_mem_addr); end
    n_cmp++; if (o_if_valid !== 1'b0) begin n_bad++; $display("FAIL ri2_valid got %b want 0", o_if_valid); end
    next_cyc();
    i_if_req = 1'b0; i_mem_rdata = 32'h7777_7777;
    #1;
    n_cmp++; if (o_if_valid !== 1'b1) begin n_bad++; $display("FAIL ri3_valid got %b want 1", o_if_valid); end
    n_cmp++; if (o_if_data !== 32'h7777_7777) begin n_bad++; $display("FAIL ri3_data got %h want 77777777", o_if_data); end
    idle_inputs();
  endtask

  initial begin
    i_reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_starve();
    test_reset_inflight();
    next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
